// File: rtl/up_slot_sched.sv
// -----------------------------------------------------------------------------
// up_slot_sched
//
// Uplink timeslot scheduler sitting between the upstream data sources
// (circuit, ctrl, busi) and the PHY tx_data ask interface.
//
//  * A slot timer divides the 40 ms frame into SLOT_NUM slots of SLOT_CYC
//    cycles. The frame pulse restarts the count at slot 0; without pulses
//    the timer free-runs and the slot index wraps.
//  * Each PHY ask picks one owner for the slot that was current when the
//    ask arrived. Priority is circuit > ctrl > busi. The burst is padded when
//    no source owns the slot, or when the owner has fewer bytes than asked.
//  * The block streams exactly ask_len bytes. It reads from the owner, or
//    sends PAD_BYTE on a pad burst.
//  * Per-source burst, pad and drop counters are kept for status readback.
//
// Ports
//  sys_clk_i    in   1   sole clock
//  rst_i        in   1   asynchronous, active-high reset
//  uplink_40ms  in   1   frame pulse; restarts the slot count at slot 0
//  circuit_ts   in   32  slot ownership bitmap, circuit source
//  ctrl_ts      in   32  slot ownership bitmap, ctrl source
//  busi_ts      in   32  slot ownership bitmap, busi source
//  ask_i        in   1   PHY burst request pulse
//  ask_len_i    in   16  burst length in bytes, sampled with ask_i
//  src_avail_i  in   48  bytes available per source (16 bits per lane)
//  src_rd_o     out  3   one-hot byte read strobe
//  src_data_i   in   24  source bytes, valid one cycle after src_rd_o
//  tx_data_o    out  8   byte to PHY (0 when tx_valid_o is low)
//  tx_valid_o   out  1   tx_data_o qualifier
//  busy_o       out  1   burst in progress (ARB through TAIL)
//  slot_idx_o   out  5   current slot index
//  stat_clr_i   in   1   synchronous clear of all counters
//  burst_cnt_o  out  96  bursts served per source (32 bits per lane)
//  pad_cnt_o    out  32  bursts sent as pad
//  drop_cnt_o   out  32  asks ignored while busy
//
// Handshake: ask_i is a single-cycle request with no ready signal. It is
// accepted only while busy_o is low. An ask that arrives while busy_o is
// high is dropped and counted. Once a burst is accepted, it always runs to
// completion unless reset intervenes. tx_valid_o marks every byte of the
// burst; the PHY cannot stall the stream.
// -----------------------------------------------------------------------------
module up_slot_sched #(
  parameter int         SLOT_NUM = 32,
  parameter int         SLOT_CYC = 204800,
  parameter logic [7:0] PAD_BYTE = 8'h55
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic        uplink_40ms,
  input  logic [31:0] circuit_ts,
  input  logic [31:0] ctrl_ts,
  input  logic [31:0] busi_ts,
  input  logic        ask_i,
  input  logic [15:0] ask_len_i,
  input  logic [47:0] src_avail_i,
  output logic [2:0]  src_rd_o,
  input  logic [23:0] src_data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        busy_o,
  output logic [4:0]  slot_idx_o,
  input  logic        stat_clr_i,
  output logic [95:0] burst_cnt_o,
  output logic [31:0] pad_cnt_o,
  output logic [31:0] drop_cnt_o
);

  localparam int              TW         = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(SLOT_CYC - 1);
  localparam logic [4:0]      SLOT_LAST  = 5'(SLOT_NUM - 1);

  localparam logic [1:0] OWN_CIRCUIT = 2'd0;
  localparam logic [1:0] OWN_CTRL    = 2'd1;
  localparam logic [1:0] OWN_BUSI    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_RD   = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // ---------------------------------------------------------------------------
  // Slot timer
  // ---------------------------------------------------------------------------
  logic [TW-1:0] timer;
  logic [4:0]    slot_idx;
  logic          slot_tick;

  assign slot_tick = (timer == TIMER_LAST);

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer    <= '0;
      slot_idx <= '0;
    end else if (uplink_40ms) begin
      timer    <= '0;
      slot_idx <= '0;
    end else if (slot_tick) begin
      timer    <= '0;
      slot_idx <= (slot_idx == SLOT_LAST) ? 5'd0 : slot_idx + 5'd1;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign slot_idx_o = slot_idx;

  // ---------------------------------------------------------------------------
  // Burst context
  // ---------------------------------------------------------------------------
  logic [15:0] len_q;
  logic [4:0]  slot_q;
  logic [1:0]  owner_q;
  logic        pad_q;
  logic [15:0] cnt_q;
  logic        tx_valid_q;

  logic        ask_accept;
  logic        burst_done;
  logic        busy;

  // Ownership lookup for the slot latched at ask time. Later slot ticks and
  // frame pulses do not move the burst to a different owner.
  logic        own_circuit;
  logic        own_ctrl;
  logic        own_busi;
  logic [1:0]  arb_owner;
  logic        arb_none;
  logic [15:0] arb_avail;
  logic        arb_pad;

  always_comb begin
    own_circuit = circuit_ts[slot_q];
    own_ctrl    = ctrl_ts[slot_q];
    own_busi    = busi_ts[slot_q];
    arb_owner   = OWN_CIRCUIT;
    arb_none    = 1'b0;
    if (own_circuit) begin
      arb_owner = OWN_CIRCUIT;
    end else if (own_ctrl) begin
      arb_owner = OWN_CTRL;
    end else if (own_busi) begin
      arb_owner = OWN_BUSI;
    end else begin
      arb_none = 1'b1;
    end
  end

  always_comb begin
    arb_avail = '0;
    case (arb_owner)
      OWN_CIRCUIT: arb_avail = src_avail_i[15:0];
      OWN_CTRL:    arb_avail = src_avail_i[31:16];
      OWN_BUSI:    arb_avail = src_avail_i[47:32];
      default:     arb_avail = '0;
    endcase
  end

  // A short source pads the whole burst. Bursts are never split between
  // source bytes and pad bytes.
  assign arb_pad = arb_none || (arb_avail < len_q);

  assign ask_accept = (state == S_IDLE) && ask_i && (ask_len_i != 16'd0);

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q   <= '0;
      slot_q  <= '0;
      owner_q <= OWN_CIRCUIT;
      pad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (ask_accept) begin
        // Latch the slot register value of the ask cycle. A frame pulse or
        // slot tick on the same edge only affects later asks.
        len_q  <= ask_len_i;
        slot_q <= slot_idx;
      end
      if (state == S_ARB) begin
        owner_q <= arb_owner;
        pad_q   <= arb_pad;
        cnt_q   <= len_q - 16'd1;
      end else if ((state == S_RD) && (cnt_q != 16'd0)) begin
        cnt_q <= cnt_q - 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ask_accept) state_nxt = S_ARB;
      S_ARB:   state_nxt = S_RD;
      S_RD:    if (cnt_q == 16'd0) state_nxt = S_TAIL;
      S_TAIL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    burst_done = (state == S_TAIL);
    src_rd_o   = 3'b000;
    if ((state == S_RD) && !pad_q) begin
      src_rd_o = 3'b001 << owner_q;
    end
  end

  assign busy_o = busy;

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  // Each read returns its byte one cycle later. tx_valid is therefore the RD
  // state delayed by one cycle, and the data path is a pure lane mux. The last
  // byte leaves during TAIL.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= (state == S_RD);
    end
  end

  assign tx_valid_o = tx_valid_q;

  always_comb begin
    tx_data_o = 8'h00;
    if (tx_valid_q) begin
      if (pad_q) begin
        tx_data_o = PAD_BYTE;
      end else begin
        case (owner_q)
          OWN_CIRCUIT: tx_data_o = src_data_i[7:0];
          OWN_CTRL:    tx_data_o = src_data_i[15:8];
          OWN_BUSI:    tx_data_o = src_data_i[23:16];
          default:     tx_data_o = 8'h00;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status counters (wrap naturally; clear beats a same-cycle increment)
  // ---------------------------------------------------------------------------
  logic [31:0] cnt_circuit;
  logic [31:0] cnt_ctrl;
  logic [31:0] cnt_busi;
  logic [31:0] cnt_pad;
  logic [31:0] cnt_drop;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_circuit <= '0;
      cnt_ctrl    <= '0;
      cnt_busi    <= '0;
      cnt_pad     <= '0;
      cnt_drop    <= '0;
    end else if (stat_clr_i) begin
      cnt_circuit <= '0;
      cnt_ctrl    <= '0;
      cnt_busi    <= '0;
      cnt_pad     <= '0;
      cnt_drop    <= '0;
    end else begin
      if (burst_done) begin
        if (pad_q) begin
          cnt_pad <= cnt_pad + 32'd1;
        end else begin
          case (owner_q)
            OWN_CIRCUIT: cnt_circuit <= cnt_circuit + 32'd1;
            OWN_CTRL:    cnt_ctrl    <= cnt_ctrl + 32'd1;
            OWN_BUSI:    cnt_busi    <= cnt_busi + 32'd1;
            default:     cnt_circuit <= cnt_circuit;
          endcase
        end
      end
      if (ask_i && busy) begin
        cnt_drop <= cnt_drop + 32'd1;
      end
    end
  end

  assign burst_cnt_o = {cnt_busi, cnt_ctrl, cnt_circuit};
  assign pad_cnt_o   = cnt_pad;
  assign drop_cnt_o  = cnt_drop;

endmodule

// File: tb/tb_up_slot_sched.sv
// -----------------------------------------------------------------------------
// tb_up_slot_sched
//
// Testbench for up_slot_sched. It runs with a short slot period so that a
// whole frame fits in a few hundred cycles.
//
// Expected values come from a reference model held in the bench:
//  * the slot is computed from the number of cycles since the last frame
//    pulse or reset;
//  * the owner is chosen by the priority and byte-availability rule;
//  * the byte stream comes from a per-lane source memory;
//  * the counters are plain integers updated as events occur.
// -----------------------------------------------------------------------------
module tb_up_slot_sched;

  localparam int         SLOT_NUM = 32;
  localparam int         SLOT_CYC = 16;
  localparam logic [7:0] PAD      = 8'h55;

  // clock / reset -------------------------------------------------------------
  logic sys_clk_i = 1'b0;
  logic rst_i     = 1'b1;
  always #5 sys_clk_i = ~sys_clk_i;

  logic        uplink_40ms = 1'b0;
  logic [31:0] circuit_ts  = '0;
  logic [31:0] ctrl_ts     = '0;
  logic [31:0] busi_ts     = '0;
  logic        ask_i       = 1'b0;
  logic [15:0] ask_len_i   = '0;
  logic [47:0] src_avail_i = '0;
  logic [2:0]  src_rd_o;
  logic [23:0] src_data_i  = '0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        busy_o;
  logic [4:0]  slot_idx_o;
  logic        stat_clr_i  = 1'b0;
  logic [95:0] burst_cnt_o;
  logic [31:0] pad_cnt_o;
  logic [31:0] drop_cnt_o;

  up_slot_sched #(
    .SLOT_NUM(SLOT_NUM),
    .SLOT_CYC(SLOT_CYC),
    .PAD_BYTE(PAD)
  ) dut (
    .sys_clk_i  (sys_clk_i),
    .rst_i      (rst_i),
    .uplink_40ms(uplink_40ms),
    .circuit_ts (circuit_ts),
    .ctrl_ts    (ctrl_ts),
    .busi_ts    (busi_ts),
    .ask_i      (ask_i),
    .ask_len_i  (ask_len_i),
    .src_avail_i(src_avail_i),
    .src_rd_o   (src_rd_o),
    .src_data_i (src_data_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .busy_o     (busy_o),
    .slot_idx_o (slot_idx_o),
    .stat_clr_i (stat_clr_i),
    .burst_cnt_o(burst_cnt_o),
    .pad_cnt_o  (pad_cnt_o),
    .drop_cnt_o (drop_cnt_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // cycle counter and slot reference --------------------------------------------
  longint cyc        = 0;
  longint frame_edge = 0;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  function automatic logic [4:0] model_slot();
    return 5'(((cyc - frame_edge) / SLOT_CYC) % SLOT_NUM);
  endfunction

  // source model: a read returns the next byte of that lane's memory one cycle later
  logic [7:0] mem [3][4096];
  int         ptr [3] = '{0, 0, 0};
  always @(posedge sys_clk_i) begin
    for (int l = 0; l < 3; l++) begin
      if (src_rd_o[l]) begin
        src_data_i[l*8 +: 8] <= mem[l][ptr[l]];
        ptr[l]               <= (ptr[l] + 1) % 4096;
      end
    end
  end

  // scoreboard ------------------------------------------------------------------
  logic [7:0]  exp_q[$];
  logic [31:0] exp_burst [3] = '{32'd0, 32'd0, 32'd0};
  logic [31:0] exp_pad  = '0;
  logic [31:0] exp_drop = '0;

  // owner rule: circuit > ctrl > busi; 3 means pad
  function automatic int pick(input logic [4:0] s, input int len);
    int o;
    if (circuit_ts[s])   o = 0;
    else if (ctrl_ts[s]) o = 1;
    else if (busi_ts[s]) o = 2;
    else return 3;
    if (int'(src_avail_i[16*o +: 16]) < len) return 3;
    return o;
  endfunction

  // driver tasks ------------------------------------------------------------------
  task automatic pulse_frame();
    @(negedge sys_clk_i);
    uplink_40ms = 1'b1;
    frame_edge  = cyc + 1;
    @(negedge sys_clk_i);
    uplink_40ms = 1'b0;
  endtask

  task automatic wait_slot(input logic [4:0] s);
    int n;
    n = 0;
    while (model_slot() != s && n < SLOT_CYC * SLOT_NUM + 4) begin
      @(negedge sys_clk_i);
      n++;
    end
    tests_run++;
    if (model_slot() != s) begin
      tests_failed++;
      $display("FAIL wait_slot: timed out, model slot %0d, wanted %0d", model_slot(), s);
    end
  endtask

  // One ask followed by cycle-by-cycle checks. The optional events are given
  // as offsets in cycles after the ask cycle (0 means none): a dropped ask, a
  // frame pulse, a counter clear and a reset.
  task automatic run_burst(input int len, input int drop_k, input int pulse_k,
                           input int clr_k, input int rst_k);
    int         own;
    int         start;
    logic [4:0] es;
    logic [4:0] exp_ctl;
    logic [2:0] exp_rd;
    logic [7:0] b;
    @(negedge sys_clk_i);
    own   = pick(model_slot(), len);
    start = (own < 3) ? ptr[own] : 0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      if (own == 3) exp_q.push_back(PAD);
      else          exp_q.push_back(mem[own][(start + i) % 4096]);
    end
    ask_i     = 1'b1;
    ask_len_i = 16'(len);
    for (int k = 1; k <= len + 4; k++) begin
      @(negedge sys_clk_i);
      es          = model_slot();
      ask_i       = (k == drop_k);
      stat_clr_i  = (k == clr_k);
      uplink_40ms = (k == pulse_k);
      if (k == pulse_k) frame_edge = cyc + 1;
      if (k == rst_k) rst_i = 1'b1;
      #1;
      if (rst_k != 0 && k >= rst_k) begin
        tests_run++;
        if ({busy_o, src_rd_o, tx_valid_o} !== 5'b0) begin
          tests_failed++;
          $display("FAIL rst_outputs k=%0d: busy/rd/valid got %b, want 00000", k,
                   {busy_o, src_rd_o, tx_valid_o});
        end
      end else begin
        exp_rd  = (k >= 2 && k <= len + 1 && own < 3) ? (3'b001 << own) : 3'b000;
        exp_ctl = {(k <= len + 2), exp_rd, (k >= 3 && k <= len + 2)};
        tests_run++;
        if ({busy_o, src_rd_o, tx_valid_o} !== exp_ctl) begin
          tests_failed++;
          $display("FAIL burst_ctl k=%0d len=%0d: busy/rd/valid got %b, want %b", k, len,
                   {busy_o, src_rd_o, tx_valid_o}, exp_ctl);
        end
        tests_run++;
        if (slot_idx_o !== es) begin
          tests_failed++;
          $display("FAIL slot_idx k=%0d: got %0d, want %0d", k, slot_idx_o, es);
        end
        if (tx_valid_o === 1'b1) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL tx_data k=%0d: extra byte %02h", k, tx_data_o);
          end else begin
            b = exp_q.pop_front();
            if (tx_data_o !== b) begin
              tests_failed++;
              $display("FAIL tx_data k=%0d: got %02h, want %02h", k, tx_data_o, b);
            end
          end
        end
        // counter reference: a clear wins over any increment in the same cycle
        if (k == clr_k) begin
          exp_burst = '{32'd0, 32'd0, 32'd0};
          exp_pad   = '0;
          exp_drop  = '0;
        end else begin
          if (k == drop_k && k <= len + 2) exp_drop++;
          if (k == len + 2) begin
            if (own == 3) exp_pad++;
            else          exp_burst[own]++;
          end
        end
      end
    end
    ask_i       = 1'b0;
    stat_clr_i  = 1'b0;
    uplink_40ms = 1'b0;
    if (rst_k != 0) begin
      @(negedge sys_clk_i);
      rst_i      = 1'b0;
      frame_edge = cyc;
      exp_q.delete();
      exp_burst = '{32'd0, 32'd0, 32'd0};
      exp_pad   = '0;
      exp_drop  = '0;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL tx_bytes: %0d bytes missing of %0d", exp_q.size(), len);
    end
    tests_run++;
    if (burst_cnt_o !== {exp_burst[2], exp_burst[1], exp_burst[0]}) begin
      tests_failed++;
      $display("FAIL burst_cnt: got %h, want %h", burst_cnt_o,
               {exp_burst[2], exp_burst[1], exp_burst[0]});
    end
    tests_run++;
    if (pad_cnt_o !== exp_pad) begin
      tests_failed++;
      $display("FAIL pad_cnt: got %0d, want %0d", pad_cnt_o, exp_pad);
    end
    tests_run++;
    if (drop_cnt_o !== exp_drop) begin
      tests_failed++;
      $display("FAIL drop_cnt: got %0d, want %0d", drop_cnt_o, exp_drop);
    end
  endtask

  // scenarios -------------------------------------------------------------------
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge sys_clk_i);
    tests_run++;
    if ({src_rd_o, tx_data_o, tx_valid_o, busy_o, slot_idx_o, burst_cnt_o, pad_cnt_o,
         drop_cnt_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rd=%b data=%h valid=%b busy=%b slot=%0d cnt=%h/%h/%h, want all 0",
               src_rd_o, tx_data_o, tx_valid_o, busy_o, slot_idx_o, burst_cnt_o, pad_cnt_o,
               drop_cnt_o);
    end
    rst_i      = 1'b0;
    frame_edge = cyc;
    repeat (2) @(negedge sys_clk_i);
    tests_run++;
    if ({busy_o, slot_idx_o} !== {1'b0, model_slot()}) begin
      tests_failed++;
      $display("FAIL after_reset: busy=%b slot=%0d, want 0 and %0d", busy_o, slot_idx_o,
               model_slot());
    end
  endtask

  task automatic test_basic();
    pulse_frame();
    circuit_ts  = 32'h1;
    ctrl_ts     = '0;
    busi_ts     = '0;
    src_avail_i = {16'd0, 16'd0, 16'd10};
    for (int i = 0; i < 4; i++) mem[0][(ptr[0] + i) % 4096] = 8'hA0 + 8'(i);
    run_burst(4, 0, 0, 0, 0);
  endtask

  task automatic test_pad();
    wait_slot(5'd3);
    circuit_ts  = '0;
    ctrl_ts     = 32'h8;
    busi_ts     = 32'h8;
    src_avail_i = {16'd100, 16'd2, 16'd0};
    run_burst(5, 0, 0, 0, 0);
  endtask

  task automatic test_priority();
    int p2;
    wait_slot(5'd5);
    circuit_ts  = '0;
    ctrl_ts     = 32'h20;
    busi_ts     = 32'h20;
    src_avail_i = {16'd100, 16'd100, 16'd0};
    p2 = ptr[2];
    run_burst(3, 0, 0, 0, 0);
    tests_run++;
    if (ptr[2] != p2) begin
      tests_failed++;
      $display("FAIL busi_reads: got %0d reads, want 0", ptr[2] - p2);
    end
  endtask

  task automatic test_back_to_back();
    circuit_ts  = 32'hFFFF_FFFF;
    src_avail_i = {16'd50, 16'd50, 16'd50};
    run_burst(8, 2, 0, 0, 0);
    run_burst(2, 0, 0, 0, 0);
    run_burst(1, 3, 0, 0, 0);
  endtask

  task automatic test_slot_wrap();
    logic [4:0] prev;
    logic       seen_wrap;
    pulse_frame();
    prev      = 5'd0;
    seen_wrap = 1'b0;
    for (int n = 0; n < SLOT_CYC * SLOT_NUM + 8; n++) begin
      @(negedge sys_clk_i);
      tests_run++;
      if (slot_idx_o !== model_slot()) begin
        tests_failed++;
        $display("FAIL slot_run n=%0d: got %0d, want %0d", n, slot_idx_o, model_slot());
      end
      if (prev == 5'd31 && slot_idx_o == 5'd0) seen_wrap = 1'b1;
      prev = slot_idx_o;
    end
    tests_run++;
    if (!seen_wrap) begin
      tests_failed++;
      $display("FAIL slot_wrap: got no 31->0 transition, want one");
    end
    // frame pulse in the middle of a burst
    ctrl_ts     = 32'hFFFF_FFFF;
    circuit_ts  = '0;
    src_avail_i = {16'd0, 16'd40, 16'd0};
    run_burst(10, 0, 4, 0, 0);
  endtask

  task automatic test_len_zero();
    @(negedge sys_clk_i);
    ask_i     = 1'b1;
    ask_len_i = 16'd0;
    @(negedge sys_clk_i);
    ask_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge sys_clk_i);
      tests_run++;
      if ({busy_o, src_rd_o, tx_valid_o} !== 5'b0) begin
        tests_failed++;
        $display("FAIL len_zero n=%0d: busy/rd/valid got %b, want 00000", n,
                 {busy_o, src_rd_o, tx_valid_o});
      end
    end
    tests_run++;
    if ({burst_cnt_o, pad_cnt_o, drop_cnt_o} !== {exp_burst[2], exp_burst[1], exp_burst[0],
                                                  exp_pad, exp_drop}) begin
      tests_failed++;
      $display("FAIL len_zero_cnt: got %h/%0d/%0d, want unchanged", burst_cnt_o, pad_cnt_o,
               drop_cnt_o);
    end
  endtask

  task automatic test_stat_clr();
    circuit_ts  = 32'hFFFF_FFFF;
    src_avail_i = {16'd9, 16'd9, 16'd9};
    run_burst(3, 1, 0, 5, 0);  // clear lands on the increment cycle of the burst
    run_burst(2, 0, 0, 0, 0);
  endtask

  task automatic test_rst_mid_burst();
    circuit_ts  = '0;
    ctrl_ts     = '0;
    busi_ts     = 32'hFFFF_FFFF;
    src_avail_i = {16'd20, 16'd0, 16'd0};
    run_burst(6, 0, 0, 0, 5);  // reset during the 3rd byte
    tests_run++;
    if (slot_idx_o !== model_slot()) begin
      tests_failed++;
      $display("FAIL rst_slot: got %0d, want %0d", slot_idx_o, model_slot());
    end
  endtask

  task automatic test_random();
    int len;
    int drop_k;
    for (int it = 0; it < 40; it++) begin
      circuit_ts  = $urandom() & $urandom();
      ctrl_ts     = $urandom() & $urandom();
      busi_ts     = $urandom();
      src_avail_i = {16'($urandom_range(0, 30)), 16'($urandom_range(0, 30)),
                     16'($urandom_range(0, 30))};
      len    = $urandom_range(1, 24);
      drop_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 2) : 0;
      run_burst(len, drop_k, 0, 0, 0);
      repeat ($urandom_range(0, 20)) @(negedge sys_clk_i);
    end
  endtask

  // watchdog --------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // main ------------------------------------------------------------------------
  initial begin
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 4096; i++) mem[l][i] = 8'($urandom());
    test_reset();
    test_basic();
    test_pad();
    test_priority();
    test_back_to_back();
    test_slot_wrap();
    test_len_zero();
    test_stat_clr();
    test_rst_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
